// File: rtl/pixel_fetch_pkg.sv
// Shared VGA geometry, color codes and the pipeline bundle for pixel_fetch.
// Also holds the canvas address helper shared by read and write paths.
package pixel_fetch_pkg;

  localparam int H_ACT    = 640;
  localparam int V_ACT    = 480;
  localparam int CANVAS_W = 320;
  localparam int CANVAS_H = 240;
  localparam int ADDR_W   = 17;
  localparam int BRUSH_R  = 4;

  typedef logic [2:0]        color_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam color_t COLOR_BLANK = 3'b000;

  typedef struct packed {
    logic active;
    logic hsync_n;
    logic vsync_n;
    logic brush;
  } strobe_t;

  // row*320 + col as two shifts and adds
  function automatic addr_t canvas_addr(
    input logic [8:0] row,
    input logic [8:0] col
  );
    addr_t r;
    addr_t c;
    r = addr_t'(row);
    c = addr_t'(col);
    return (r << 8) + (r << 6) + c;
  endfunction

endpackage

// File: rtl/pixel_fetch_if.sv
// Paint request handshake between the command interface and pixel_fetch.
// The command side drives the request, pixel_fetch answers with ready.
interface pixel_fetch_if;
  import pixel_fetch_pkg::*;

  logic       paintValid;
  logic       paintReady;
  logic [8:0] paintX;
  logic [7:0] paintY;
  color_t     paintColor;

  modport master (
    output paintValid,
    output paintX,
    output paintY,
    output paintColor,
    input  paintReady
  );

  modport slave (
    input  paintValid,
    input  paintX,
    input  paintY,
    input  paintColor,
    output paintReady
  );

endinterface

// File: rtl/pixel_fetch_brush_hit.sv
// Square-window test of the scan position against the brush centre.
// Differences are signed so a cursor near a screen edge clips naturally.
module brush_hit
  import pixel_fetch_pkg::*;
(
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  input  logic [9:0] cur_x_i,
  input  logic [9:0] cur_y_i,
  input  logic       active_i,
  output logic       hit_o
);

  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic [10:0]        adx;
  logic [10:0]        ady;

  assign dx  = $signed({1'b0, x_i}) - $signed({1'b0, cur_x_i});
  assign dy  = $signed({1'b0, y_i}) - $signed({1'b0, cur_y_i});
  assign adx = dx[10] ? 11'(-dx) : 11'(dx);
  assign ady = dy[10] ? 11'(-dy) : 11'(dy);

  assign hit_o = active_i
              && (adx <= 11'(BRUSH_R))
              && (ady <= 11'(BRUSH_R));

endmodule

// File: rtl/pixel_fetch.sv
// Framebuffer fetch stage: scan position to address, color and brush two
// cycles later with matching strobes; owns the blanking-time write port.
module pixel_fetch
  import pixel_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic [9:0]   x,
  input  logic [9:0]   y,
  input  logic         active,
  input  logic         hsync_n,
  input  logic         vsync_n,
  input  logic [9:0]   cursorX,
  input  logic [9:0]   cursorY,
  input  logic         cursorValid,
  pixel_fetch_if.slave paint,
  output addr_t        fbAddr,
  output logic         fbWe,
  output color_t       fbWdata,
  input  color_t       fbRdata,
  output color_t       colorCode,
  output logic         brush,
  output logic         activeOut,
  output logic         hsyncOut_n,
  output logic         vsyncOut_n
);

  localparam strobe_t STROBE_IDLE = '{
    active:  1'b0,
    hsync_n: 1'b1,
    vsync_n: 1'b1,
    brush:   1'b0
  };

  logic       accept;
  logic       hit;
  logic       vs_fall;

  addr_t      fb_addr_q, fb_addr_d;
  logic       fb_we_q, fb_we_d;
  color_t     fb_wdata_q, fb_wdata_d;

  logic [9:0] pend_x_q, pend_x_d;
  logic [9:0] pend_y_q, pend_y_d;
  logic [9:0] live_x_q, live_x_d;
  logic [9:0] live_y_q, live_y_d;
  logic       vs_q;

  strobe_t    s1_q, s1_d;
  strobe_t    s2_q;
  strobe_t    out_q;
  color_t     color_q, color_d;

  assign paint.paintReady = !active && reset_n;
  assign accept = paint.paintValid && paint.paintReady;
  assign vs_fall = vs_q && !vsync_n;

  brush_hit u_brush_hit (
    .x_i      (x),
    .y_i      (y),
    .cur_x_i  (live_x_q),
    .cur_y_i  (live_y_q),
    .active_i (active),
    .hit_o    (hit)
  );

  always_comb begin
    fb_addr_d  = canvas_addr(y[9:1], x[9:1]);
    fb_we_d    = 1'b0;
    fb_wdata_d = fb_wdata_q;
    if (accept) begin
      fb_addr_d  = canvas_addr({1'b0, paint.paintY}, paint.paintX);
      fb_we_d    = 1'b1;
      fb_wdata_d = paint.paintColor;
    end
  end

  // live cursor only moves at frame start so the brush never tears
  always_comb begin
    pend_x_d = cursorValid ? cursorX : pend_x_q;
    pend_y_d = cursorValid ? cursorY : pend_y_q;
    live_x_d = vs_fall ? pend_x_q : live_x_q;
    live_y_d = vs_fall ? pend_y_q : live_y_q;
  end

  always_comb begin
    s1_d = '{
      active:  active,
      hsync_n: hsync_n,
      vsync_n: vsync_n,
      brush:   hit
    };
    color_d = s2_q.active ? fbRdata : COLOR_BLANK;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fb_addr_q  <= '0;
      fb_we_q    <= 1'b0;
      fb_wdata_q <= COLOR_BLANK;
      pend_x_q   <= '0;
      pend_y_q   <= '0;
      live_x_q   <= '0;
      live_y_q   <= '0;
      vs_q       <= 1'b1;
      s1_q       <= STROBE_IDLE;
      s2_q       <= STROBE_IDLE;
      out_q      <= STROBE_IDLE;
      color_q    <= COLOR_BLANK;
    end else begin
      fb_addr_q  <= fb_addr_d;
      fb_we_q    <= fb_we_d;
      fb_wdata_q <= fb_wdata_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      live_x_q   <= live_x_d;
      live_y_q   <= live_y_d;
      vs_q       <= vsync_n;
      s1_q       <= s1_d;
      s2_q       <= s1_q;
      out_q      <= s2_q;
      color_q    <= color_d;
    end
  end

  assign fbAddr     = fb_addr_q;
  assign fbWe       = fb_we_q;
  assign fbWdata    = fb_wdata_q;
  assign colorCode  = color_q;
  assign brush      = out_q.brush;
  assign activeOut  = out_q.active;
  assign hsyncOut_n = out_q.hsync_n;
  assign vsyncOut_n = out_q.vsync_n;

endmodule

// File: doc/pixel_fetch.md
# pixel_fetch

Pixel source stage for the VGA path: converts the scan position from the VGA timing generator into a framebuffer read address, returns the stored 3-bit color code and a brush-cursor overlay flag two cycles later, and delays the sync/active strobes to match. Its `colorCode`/`brush` outputs feed the color decoder directly. It also owns the framebuffer write port, accepting paint requests from the command interface only during blanking.

## Interface
- `H_ACT`, 640: visible screen width in pixels.
- `V_ACT`, 480: visible screen height in lines.
- `CANVAS_W`, 320: framebuffer width (screen is 2× pixel-doubled in both axes).
- `CANVAS_H`, 240: framebuffer height.
- `ADDR_W`, 17: framebuffer address width (covers 76800 entries).
- `BRUSH_R`, 4: brush half-size in screen pixels (square, side 2·BRUSH_R+1).

- `clk`  in  1  pixel clock (one pixel per cycle).
- `reset_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `x`, `y`  in  10 each  current scan position (screen coords).
- `active`  in  1  high when (x,y) is visible.
- `hsync_n`, `vsync_n`  in  1 each  active-low syncs from timing generator.
- `cursorX`, `cursorY`  in  10 each  brush centre, screen coords.
- `cursorValid`  in  1  load `cursorX/Y` into shadow register.
- `paintValid`  in  1  paint request.
- `paintReady`  out  1  paint request can be accepted this cycle.
- `paintX`  in  9, `paintY`  in  8, `paintColor`  in  3  canvas coords and code to write.
- `fbAddr`  out  ADDR_W  framebuffer address (registered).
- `fbWe`  out  1  framebuffer write strobe (registered).
- `fbWdata`  out  3  write data (registered).
- `fbRdata`  in  3  read data, valid one cycle after `fbAddr`.
- `colorCode`  out  3  pixel color code to the decoder.
- `brush`  out  1  pixel lies inside the brush square.
- `activeOut`, `hsyncOut_n`, `vsyncOut_n`  out  1 each  delayed strobes.

## Operation
- Read address: `fbAddr = (y>>1)·CANVAS_W + (x>>1)`, computed from inputs and registered; multiply implemented as `(y>>1)<<8 + (y>>1)<<6`, width ADDR_W, no overflow for visible coords.
- Address mux: `active`=1 → read address, `fbWe`=0. `active`=0 and paint handshake → write.
- `paintReady = active==0 && reset_n==1` (combinational). Handshake completes on an edge with `paintValid && paintReady`; that edge registers `fbAddr = paintY·CANVAS_W + paintX`, `fbWdata = paintColor`, `fbWe = 1` for exactly one cycle. One write per cycle max; back-to-back writes allowed.
- Cursor: `cursorValid` loads a pending register (last value wins). Pending is copied to the live cursor on the cycle `vsync_n` falls (edge detected with a registered copy); mid-frame updates never tear.
- Brush: `|x−curX| ≤ BRUSH_R && |y−curY| ≤ BRUSH_R && active`, signed 11-bit differences; cursor near an edge clips naturally.
- Output: `colorCode = fbRdata` when delayed active=1, else `3'b000`; `brush` forced 0 when inactive.

## Timing
- Inputs sampled at edge N; `fbAddr` valid after N; `fbRdata` after N+1; `colorCode`, `brush`, `activeOut`, syncs registered at N+2. Fixed latency 2, all outputs aligned.
- Reset values: `fbAddr`=0, `fbWe`=0, `fbWdata`=0, `colorCode`=0, `brush`=0, `activeOut`=0, `hsyncOut_n`=1, `vsyncOut_n`=1, pending and live cursor = 0, sync edge register = 1.
- Reset mid-frame: outputs return to reset values on the next edge; any in-flight write is dropped (`fbWe`=0); pipeline refills normally after release.
- `paintValid` during active: stalls, accepted on first edge with `active`=0.
- `cursorValid` on the same edge as `vsync_n` fall: live takes the old pending value; new value applies next frame.

## Structure
- Canvas/screen dimensions and `BRUSH_R` go in the shared VGA parameters package; color codes (including the blank code 3'b000) stay in the shared colors package.
- One sub-module: `brush_hit` (combinational square-window comparator), instantiated once.

## Test plan
- Hold `reset_n`=0 with toggling inputs → all outputs at reset values, `paintReady`=0.
- `active`=0, paint (5,3,3'b010) → one cycle `fbWe`=1, `fbAddr`=965, `fbWdata`=3'b010.
- `active`=1, x=11,y=7, `fbRdata`=3'b100 after one cycle → `fbAddr`=965, `colorCode`=3'b100 and `activeOut`=1 two cycles after input.
- `paintValid` held during active → `paintReady`=0, no `fbWe`; write occurs on first blank cycle.
- Cursor set (100,100) mid-frame → brush uses old cursor until `vsync_n` falls; next frame (104,96) `brush`=1, (105,100) `brush`=0.
- Reset asserted mid-line → next edge `hsyncOut_n`=1, `fbWe`=0, `colorCode`=0; first valid output 2 cycles after release.
